bxclk_monitor: RTL and testbench
================================

BXCLK_MONITOR -- requirements
Module: bxclk_monitor

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  fabric clock (400 MHz, pl_clk1); same clock that generates bxclk/bxclk_ana.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 enable  in  1  monitor active; low forces IDLE.
REQ-005 clr_err  in  1  synchronous pulse; clears err_count and sticky flags.
REQ-006 bxclk_ana_in  in  1  analog-side bunch-crossing clock, synchronous to clk.
REQ-007 bxclk_in  in  1  digital-side bunch-crossing clock, synchronous to clk.
REQ-008 exp_period  in  6  expected period in clk ticks.
REQ-009 exp_delay  in  5  expected bxclk offset in ticks.
REQ-010 exp_delay_sign  in  1  expected sign: 0 = bxclk rising edge follows bxclk_ana rising edge; 1 = bxclk falling edge follows it.
REQ-011 meas_period  out  6  last measured bxclk_ana rising-to-rising interval.
REQ-012 meas_high  out  6  last measured bxclk_ana high time.
REQ-013 meas_delay  out  5  last measured offset.
REQ-014 meas_delay_sign  out  1  last measured sign.
REQ-015 meas_valid  out  1  one-cycle pulse when the meas_* outputs update.
REQ-016 locked  out  1  measurements match expectations.
REQ-017 err_count  out  8  saturating count of mismatching periods.
REQ-018 err_timeout  out  1  sticky: no bxclk_ana rising edge within TIMEOUT ticks.

Function
REQ-019 Both inputs SHALL be registered once; edges SHALL be detected from current versus previous registered sample.
REQ-020 States SHALL be IDLE, SYNC, MEASURE and LOCKED.
- IDLE -> SYNC when enable=1.
- SYNC -> MEASURE on the first bxclk_ana rising edge.
- MEASURE -> LOCKED after LOCK_COUNT consecutive matching periods.
- LOCKED -> MEASURE on any mismatch.
- Any state -> IDLE when enable=0.
REQ-021 The period counter (7 bit) SHALL be 0 at a bxclk_ana rising edge and increment each tick.
- On the next rising edge, meas_period = counter+1 (truncated to 6 bits); meas_valid pulses the same cycle.
REQ-022 meas_high SHALL equal the number of ticks bxclk_ana was sampled high in the completed period.
REQ-023 Offset measurement:
- The first bxclk edge at counter value 0..exp_period/2 SHALL define meas_delay = counter value.
- Rising edge SHALL give meas_delay_sign=0; falling edge SHALL give meas_delay_sign=1.
- Simultaneous edges on both inputs SHALL give offset 0.
REQ-024 If no bxclk edge occurs in the window, meas_delay SHALL be 31, meas_delay_sign SHALL hold, and the period SHALL count as mismatching.
REQ-025 A period SHALL match iff all three hold:
- meas_period == exp_period;
- meas_high == exp_period>>1;
- {meas_delay_sign, meas_delay} == {exp_delay_sign, exp_delay}.
REQ-026 Each mismatching period evaluated in MEASURE or LOCKED SHALL increment err_count, saturating at 255.
REQ-027 If the counter reaches TIMEOUT (64) without a bxclk_ana rising edge, the block SHALL set err_timeout, return to SYNC, and clear locked.
REQ-028 A clr_err arriving in the same cycle as an increment SHALL win: err_count becomes 0.
REQ-029 locked SHALL assert the cycle after the LOCK_COUNT-th matching meas_valid and deassert the cycle after a mismatching one.
REQ-030 Changing any exp_* input mid-operation SHALL take effect at the next comparison, with no restart.
REQ-031 Latency SHALL be 2 cycles from the input pin edge to the registered edge-detect.

Reset
REQ-032 While reset_n=0, every output SHALL be 0 and the state SHALL be IDLE.
REQ-033 Reset assertion mid-period SHALL discard partial measurements.
REQ-034 Deasserting enable SHALL clear the counters, locked and meas_valid, and SHALL keep err_count, err_timeout and the last meas_* values.

Structure
REQ-035 Package bxclk_pkg SHALL hold the state enum, LOCK_COUNT=4 and TIMEOUT=64.
REQ-036 A single sub-module, bxclk_edge_detect, SHALL register one input and produce rise/fall pulses; it SHALL be instantiated twice.

Verification
REQ-037 Drive period=10, delay=0, sign=0 (bxclk equal to bxclk_ana), matching expectations. Required: meas_period=10, meas_high=5, meas_delay=0, locked after 4 periods, err_count=0.
REQ-038 Drive period=10, delay=3, sign=1, expecting delay=3, sign=1. Required: meas_delay=3, meas_delay_sign=1, locked. Then change exp_delay to 2: locked drops after the next meas_valid and err_count increments once per period.
REQ-039 Drive period=40, delay=20, sign=0 (edge outside window). Required: meas_delay=31, never locked.
REQ-040 Lock at period=10, then hold bxclk_ana low for 70 ticks. Required: err_timeout=1, state SYNC, locked=0; after recovery, re-lock within 5 periods.
REQ-041 Force a sustained mismatch for 300 periods. Required: err_count=255. Then pulse clr_err coincident with a mismatch: err_count=0.
REQ-042 Assert reset_n low mid-period while locked. Required: all outputs 0 immediately; after release, SYNC then MEASURE.

Source files
------------

// File: rtl/bxclk_pkg.sv
// -----------------------------------------------------------------------------
// bxclk_pkg
// Shared definitions for the bunch-crossing clock monitor:
//   state_e     - monitor FSM states
//   LOCK_COUNT  - consecutive matching periods needed to declare lock
//   TIMEOUT     - ticks without a bxclk_ana rising edge before giving up
//   DELAY_NONE  - meas_delay value reported when no bxclk edge was seen
// -----------------------------------------------------------------------------
package bxclk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 64;

  localparam logic [4:0] DELAY_NONE = 5'd31;

endpackage

// File: rtl/bxclk_edge_detect.sv
// -----------------------------------------------------------------------------
// bxclk_edge_detect
// Registers one clk-synchronous input once and flags its edges by comparing
// the current registered sample with the previous one.
// Ports:
//   clk      in   fabric clock
//   reset_n  in   asynchronous active-low reset
//   sig_i    in   input to watch
//   rise_o   out  one-cycle pulse, registered sample went 0 -> 1
//   fall_o   out  one-cycle pulse, registered sample went 1 -> 0
// -----------------------------------------------------------------------------
module bxclk_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sample_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sample_q <= sig_i;
      prev_q   <= sample_q;
    end
  end

  assign rise_o = sample_q & ~prev_q;
  assign fall_o = ~sample_q & prev_q;

endmodule

// File: rtl/bxclk_monitor.sv
// -----------------------------------------------------------------------------
// bxclk_monitor
// Measures the period, high time and bxclk offset of the bunch-crossing
// clocks, compares them against the expected values and reports lock,
// mismatch count and a missing-clock timeout.
// Ports:
//   clk, reset_n              clock / asynchronous active-low reset
//   enable                    monitor active; low returns to IDLE
//   clr_err                   clears err_count and err_timeout
//   bxclk_ana_in, bxclk_in    monitored clocks (synchronous to clk)
//   exp_period/_delay/_sign   expected waveform
//   meas_period/_high/_delay/_delay_sign, meas_valid   last measurement
//   locked, err_count, err_timeout                    status
// -----------------------------------------------------------------------------
module bxclk_monitor
  import bxclk_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       clr_err,
  input  logic       bxclk_ana_in,
  input  logic       bxclk_in,
  input  logic [5:0] exp_period,
  input  logic [4:0] exp_delay,
  input  logic       exp_delay_sign,
  output logic [5:0] meas_period,
  output logic [5:0] meas_high,
  output logic [4:0] meas_delay,
  output logic       meas_delay_sign,
  output logic       meas_valid,
  output logic       locked,
  output logic [7:0] err_count,
  output logic       err_timeout
);

  logic ana_rise, ana_fall, bx_rise, bx_fall;

  bxclk_edge_detect u_ana_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .sig_i  (bxclk_ana_in),
    .rise_o (ana_rise),
    .fall_o (ana_fall)
  );

  bxclk_edge_detect u_bx_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .sig_i  (bxclk_in),
    .rise_o (bx_rise),
    .fall_o (bx_fall)
  );

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;          // tick index of the current cycle within the period
  logic [6:0] hi_q, hi_d;            // high samples seen so far this period
  logic       ana_hi_q;              // bxclk_ana level rebuilt from its edge pulses
  logic       found_q, found_d;      // bxclk edge already captured this period
  logic [4:0] dval_q, dval_d;
  logic       dsign_q, dsign_d;
  logic [2:0] match_cnt_q, match_cnt_d;
  logic [5:0] meas_period_q, meas_period_d;
  logic [5:0] meas_high_q, meas_high_d;
  logic [4:0] meas_delay_q, meas_delay_d;
  logic       meas_sign_q, meas_sign_d;
  logic       meas_valid_q, meas_valid_d;
  logic       locked_q, locked_d;
  logic [7:0] err_count_q, err_count_d;
  logic       err_timeout_q, err_timeout_d;

  // A rising edge starts a new period at index 0, so an edge of bxclk in the
  // same cycle lands at offset 0.
  logic [6:0] pos;
  logic [5:0] half_period;
  logic       ana_lvl, bx_edge, in_window, period_match, new_sign;
  logic [4:0] new_delay;

  assign pos         = ana_rise ? 7'd0 : cnt_q;
  assign half_period = {1'b0, exp_period[5:1]};
  assign ana_lvl     = ana_rise | (ana_hi_q & ~ana_fall);
  assign bx_edge     = bx_rise | bx_fall;
  assign in_window   = (pos <= {1'b0, half_period});
  assign new_delay   = found_q ? dval_q : DELAY_NONE;
  assign new_sign    = found_q ? dsign_q : meas_sign_q;
  // Full-width compares so a 64-tick count cannot alias onto period 0.
  assign period_match = found_q
                     && (cnt_q == {1'b0, exp_period})
                     && (hi_q == {1'b0, half_period})
                     && ({new_sign, new_delay} == {exp_delay_sign, exp_delay});

  always_comb begin
    logic inc_err;
    logic run_period;
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    found_d       = found_q;
    dval_d        = dval_q;
    dsign_d       = dsign_q;
    match_cnt_d   = match_cnt_q;
    meas_period_d = meas_period_q;
    meas_high_d   = meas_high_q;
    meas_delay_d  = meas_delay_q;
    meas_sign_d   = meas_sign_q;
    meas_valid_d  = 1'b0;
    locked_d      = 1'b0;
    err_count_d   = err_count_q;
    err_timeout_d = err_timeout_q;
    inc_err       = 1'b0;
    run_period    = 1'b0;

    if (!enable) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      hi_d        = '0;
      found_d     = 1'b0;
      match_cnt_d = '0;
    end else begin
      // Registered from the state so lock follows the deciding meas_valid by a cycle.
      locked_d = (state_q == ST_LOCKED);
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: begin
          if (ana_rise) begin
            state_d    = ST_MEASURE;
            run_period = 1'b1;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (ana_rise) begin
            run_period    = 1'b1;
            meas_valid_d  = 1'b1;
            meas_period_d = cnt_q[5:0];
            meas_high_d   = hi_q[5:0];
            meas_delay_d  = new_delay;
            meas_sign_d   = new_sign;
            if (period_match) begin
              if (state_q == ST_MEASURE) begin
                if (match_cnt_q == 3'(LOCK_COUNT - 1)) begin
                  state_d     = ST_LOCKED;
                  match_cnt_d = '0;
                end else begin
                  match_cnt_d = match_cnt_q + 3'd1;
                end
              end
            end else begin
              inc_err     = 1'b1;
              match_cnt_d = '0;
              state_d     = ST_MEASURE;
            end
          end else if (cnt_q == 7'(TIMEOUT)) begin
            err_timeout_d = 1'b1;
            match_cnt_d   = '0;
            state_d       = ST_SYNC;
          end else begin
            run_period = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (run_period) begin
        cnt_d = pos + 7'd1;
        hi_d  = (ana_rise ? 7'd0 : hi_q) + 7'(ana_lvl);
        if (ana_rise) begin
          found_d = bx_edge;
          dval_d  = '0;
          dsign_d = bx_fall;
        end else if (!found_q && bx_edge && in_window) begin
          found_d = 1'b1;
          dval_d  = pos[4:0];
          dsign_d = bx_fall;
        end
      end else begin
        cnt_d   = '0;
        hi_d    = '0;
        found_d = 1'b0;
      end
    end

    if (inc_err && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
    // Clearing takes priority over a same-cycle increment.
    if (clr_err) begin
      err_count_d   = '0;
      err_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hi_q          <= '0;
      ana_hi_q      <= 1'b0;
      found_q       <= 1'b0;
      dval_q        <= '0;
      dsign_q       <= 1'b0;
      match_cnt_q   <= '0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      meas_delay_q  <= '0;
      meas_sign_q   <= 1'b0;
      meas_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      err_count_q   <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      ana_hi_q      <= ana_lvl;
      found_q       <= found_d;
      dval_q        <= dval_d;
      dsign_q       <= dsign_d;
      match_cnt_q   <= match_cnt_d;
      meas_period_q <= meas_period_d;
      meas_high_q   <= meas_high_d;
      meas_delay_q  <= meas_delay_d;
      meas_sign_q   <= meas_sign_d;
      meas_valid_q  <= meas_valid_d;
      locked_q      <= locked_d;
      err_count_q   <= err_count_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign meas_period     = meas_period_q;
  assign meas_high       = meas_high_q;
  assign meas_delay      = meas_delay_q;
  assign meas_delay_sign = meas_sign_q;
  assign meas_valid      = meas_valid_q;
  assign locked          = locked_q;
  assign err_count       = err_count_q;
  assign err_timeout     = err_timeout_q;

endmodule

// File: tb/tb_bxclk_monitor.sv
// -----------------------------------------------------------------------------
// tb_bxclk_monitor
// Directed scenarios for bxclk_monitor with hand-computed expectations.
// Waveforms are generated one clk tick at a time; each scenario restarts the
// monitor from IDLE with bxclk preset to its steady level so that only the
// intended edges are seen.
// -----------------------------------------------------------------------------
module tb_bxclk_monitor;
  import bxclk_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0;
  logic       clr_err = 1'b0;
  logic       bxclk_ana_in = 1'b0;
  logic       bxclk_in = 1'b0;
  logic [5:0] exp_period = 6'd10;
  logic [4:0] exp_delay = 5'd0;
  logic       exp_delay_sign = 1'b0;
  logic [5:0] meas_period;
  logic [5:0] meas_high;
  logic [4:0] meas_delay;
  logic       meas_delay_sign;
  logic       meas_valid;
  logic       locked;
  logic [7:0] err_count;
  logic       err_timeout;

  int n_vec = 0;
  int n_err = 0;
  int mv_total = 0;
  int lk_total = 0;

  bxclk_monitor dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .clr_err        (clr_err),
    .bxclk_ana_in   (bxclk_ana_in),
    .bxclk_in       (bxclk_in),
    .exp_period     (exp_period),
    .exp_delay      (exp_delay),
    .exp_delay_sign (exp_delay_sign),
    .meas_period    (meas_period),
    .meas_high      (meas_high),
    .meas_delay     (meas_delay),
    .meas_delay_sign(meas_delay_sign),
    .meas_valid     (meas_valid),
    .locked         (locked),
    .err_count      (err_count),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (meas_valid) mv_total++;
    if (locked) lk_total++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: bxclk = bxclk_ana delayed by d; mode 1: inverted copy (falling edge
  // d ticks after the ana rise); mode 2: bxclk high on phases 20..29 only.
  task automatic run(input int p, input int d, input int mode, input int n, input int clr_tick);
    int ph;
    int bph;
    logic b;
    for (int k = 0; k < p * n; k++) begin
      ph  = k % p;
      bph = (ph - d + p) % p;
      b   = (bph < p / 2);
      bxclk_ana_in = (ph < p / 2);
      case (mode)
        0:       bxclk_in = b;
        1:       bxclk_in = ~b;
        default: bxclk_in = (ph >= 20) && (ph < 30);
      endcase
      clr_err = (k == clr_tick);
      step();
    end
    clr_err = 1'b0;
  endtask

  task automatic start_test(input logic bx0);
    enable = 1'b0;
    bxclk_ana_in = 1'b0;
    bxclk_in = bx0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    step();
    step();
    enable = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    step();
    step();
    n_vec++; if ({meas_period, meas_high, meas_delay, meas_delay_sign, meas_valid, locked, err_count, err_timeout} !== 29'd0) begin
      n_err++; $display("FAIL reset.outputs got=%h want=0", {meas_period, meas_high, meas_delay, meas_delay_sign, meas_valid, locked, err_count, err_timeout});
    end
    n_vec++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL reset.state got=%0d want=%0d", dut.state_q, ST_IDLE); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
    n_vec++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL reset.idle_disabled got=%0d want=%0d", dut.state_q, ST_IDLE); end
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL reset.err_count got=%0d want=0", err_count); end
    $display("test_reset: state=%0d err=%0d", dut.state_q, err_count);
  endtask

  task automatic test_match();
    int mv0;
    exp_period = 6'd10; exp_delay = 5'd0; exp_delay_sign = 1'b0;
    start_test(1'b0);
    mv0 = mv_total;
    run(10, 0, 0, 4, -1);
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL match.locked_early got=%0b want=0", locked); end
    n_vec++; if (mv_total - mv0 !== 3) begin n_err++; $display("FAIL match.valid_count3 got=%0d want=3", mv_total - mv0); end
    run(10, 0, 0, 2, -1);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL match.locked got=%0b want=1", locked); end
    n_vec++; if (meas_period !== 6'd10) begin n_err++; $display("FAIL match.period got=%0d want=10", meas_period); end
    n_vec++; if (meas_high !== 6'd5) begin n_err++; $display("FAIL match.high got=%0d want=5", meas_high); end
    n_vec++; if (meas_delay !== 5'd0) begin n_err++; $display("FAIL match.delay got=%0d want=0", meas_delay); end
    n_vec++; if (meas_delay_sign !== 1'b0) begin n_err++; $display("FAIL match.sign got=%0b want=0", meas_delay_sign); end
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL match.err_count got=%0d want=0", err_count); end
    n_vec++; if (mv_total - mv0 !== 5) begin n_err++; $display("FAIL match.valid_count5 got=%0d want=5", mv_total - mv0); end
    $display("test_match: period=%0d high=%0d delay=%0d sign=%0b locked=%0b err=%0d", meas_period, meas_high, meas_delay, meas_delay_sign, locked, err_count);
  endtask

  task automatic test_delay_sign();
    exp_period = 6'd10; exp_delay = 5'd3; exp_delay_sign = 1'b1;
    start_test(1'b1);
    run(10, 3, 1, 6, -1);
    n_vec++; if (meas_delay !== 5'd3) begin n_err++; $display("FAIL delay.delay got=%0d want=3", meas_delay); end
    n_vec++; if (meas_delay_sign !== 1'b1) begin n_err++; $display("FAIL delay.sign got=%0b want=1", meas_delay_sign); end
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL delay.locked got=%0b want=1", locked); end
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL delay.err_count0 got=%0d want=0", err_count); end
    exp_delay = 5'd2;
    run(10, 3, 1, 1, -1);
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL delay.unlock got=%0b want=0", locked); end
    n_vec++; if (err_count !== 8'd1) begin n_err++; $display("FAIL delay.err_count1 got=%0d want=1", err_count); end
    run(10, 3, 1, 2, -1);
    n_vec++; if (err_count !== 8'd3) begin n_err++; $display("FAIL delay.err_count3 got=%0d want=3", err_count); end
    n_vec++; if (meas_delay !== 5'd3) begin n_err++; $display("FAIL delay.delay_kept got=%0d want=3", meas_delay); end
    $display("test_delay_sign: delay=%0d sign=%0b locked=%0b err=%0d", meas_delay, meas_delay_sign, locked, err_count);
  endtask

  // Expectation stays at period 10, so the offset window is ticks 0..5 and the
  // bxclk edges at 20 and 30 of a 40-tick period fall outside it.
  task automatic test_window();
    int lk0;
    exp_period = 6'd10; exp_delay = 5'd0; exp_delay_sign = 1'b0;
    start_test(1'b0);
    n_vec++; if (meas_delay !== 5'd3) begin n_err++; $display("FAIL window.meas_kept got=%0d want=3", meas_delay); end
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL window.cleared got=%0d want=0", err_count); end
    lk0 = lk_total;
    run(40, 0, 2, 3, -1);
    n_vec++; if (meas_delay !== 5'd31) begin n_err++; $display("FAIL window.delay got=%0d want=31", meas_delay); end
    n_vec++; if (meas_delay_sign !== 1'b1) begin n_err++; $display("FAIL window.sign_hold got=%0b want=1", meas_delay_sign); end
    n_vec++; if (meas_period !== 6'd40) begin n_err++; $display("FAIL window.period got=%0d want=40", meas_period); end
    n_vec++; if (meas_high !== 6'd20) begin n_err++; $display("FAIL window.high got=%0d want=20", meas_high); end
    n_vec++; if (err_count !== 8'd2) begin n_err++; $display("FAIL window.err_count got=%0d want=2", err_count); end
    n_vec++; if (lk_total - lk0 !== 0) begin n_err++; $display("FAIL window.never_locked got=%0d want=0", lk_total - lk0); end
    $display("test_window: delay=%0d sign=%0b period=%0d err=%0d", meas_delay, meas_delay_sign, meas_period, err_count);
  endtask

  task automatic test_timeout();
    exp_period = 6'd10; exp_delay = 5'd0; exp_delay_sign = 1'b0;
    start_test(1'b0);
    run(10, 0, 0, 6, -1);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL timeout.pre_locked got=%0b want=1", locked); end
    bxclk_ana_in = 1'b0;
    bxclk_in = 1'b0;
    repeat (70) step();
    n_vec++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout.flag got=%0b want=1", err_timeout); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL timeout.locked got=%0b want=0", locked); end
    n_vec++; if (dut.state_q !== ST_SYNC) begin n_err++; $display("FAIL timeout.state got=%0d want=%0d", dut.state_q, ST_SYNC); end
    run(10, 0, 0, 5, -1);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL timeout.relock got=%0b want=1", locked); end
    n_vec++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL timeout.sticky got=%0b want=1", err_timeout); end
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL timeout.err_count got=%0d want=0", err_count); end
    $display("test_timeout: err_timeout=%0b locked=%0b err=%0d", err_timeout, locked, err_count);
  endtask

  task automatic test_saturation();
    exp_period = 6'd12; exp_delay = 5'd0; exp_delay_sign = 1'b0;
    start_test(1'b0);
    n_vec++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL sat.timeout_cleared got=%0b want=0", err_timeout); end
    run(10, 0, 0, 100, -1);
    n_vec++; if (err_count !== 8'd99) begin n_err++; $display("FAIL sat.err_99 got=%0d want=99", err_count); end
    run(10, 0, 0, 200, -1);
    n_vec++; if (err_count !== 8'd255) begin n_err++; $display("FAIL sat.err_255 got=%0d want=255", err_count); end
    run(10, 0, 0, 1, 1);
    n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL sat.clr_wins got=%0d want=0", err_count); end
    run(10, 0, 0, 1, -1);
    n_vec++; if (err_count !== 8'd1) begin n_err++; $display("FAIL sat.count_resumes got=%0d want=1", err_count); end
    $display("test_saturation: err=%0d locked=%0b", err_count, locked);
  endtask

  task automatic test_reset_mid();
    int mv0;
    exp_period = 6'd10; exp_delay = 5'd0; exp_delay_sign = 1'b0;
    start_test(1'b0);
    run(10, 0, 0, 6, -1);
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL rstmid.pre_locked got=%0b want=1", locked); end
    bxclk_ana_in = 1'b1;
    bxclk_in = 1'b1;
    step();
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if ({meas_period, meas_high, meas_delay, meas_delay_sign, meas_valid, locked, err_count, err_timeout} !== 29'd0) begin
      n_err++; $display("FAIL rstmid.outputs got=%h want=0", {meas_period, meas_high, meas_delay, meas_delay_sign, meas_valid, locked, err_count, err_timeout});
    end
    n_vec++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL rstmid.state_idle got=%0d want=%0d", dut.state_q, ST_IDLE); end
    bxclk_ana_in = 1'b0;
    bxclk_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    n_vec++; if (dut.state_q !== ST_SYNC) begin n_err++; $display("FAIL rstmid.state_sync got=%0d want=%0d", dut.state_q, ST_SYNC); end
    step();
    mv0 = mv_total;
    run(10, 0, 0, 1, -1);
    n_vec++; if (dut.state_q !== ST_MEASURE) begin n_err++; $display("FAIL rstmid.state_measure got=%0d want=%0d", dut.state_q, ST_MEASURE); end
    n_vec++; if (mv_total - mv0 !== 0) begin n_err++; $display("FAIL rstmid.no_valid got=%0d want=0", mv_total - mv0); end
    n_vec++; if (meas_period !== 6'd0) begin n_err++; $display("FAIL rstmid.partial_discarded got=%0d want=0", meas_period); end
    $display("test_reset_mid: state=%0d period=%0d locked=%0b", dut.state_q, meas_period, locked);
  endtask

  initial begin
    test_reset();
    test_match();
    test_delay_sign();
    test_window();
    test_timeout();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
